// File: rtl/dff_chain_monitor.sv
// dff_chain_monitor: drives a test pattern into DFF chains, counts per-channel mismatches against
// the pattern delayed by LAT cycles, and serialises counter snapshots to an asynchronous host.
module dff_chain_monitor #(
    parameter int NUM_CH      = 20,
    parameter int CNT_W       = 12,
    parameter int LAT         = 2,
    parameter bit CLR_ON_SAVE = 1'b1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      en,
    input  logic [1:0]                mode,
    output logic                      dut_data,
    input  logic [NUM_CH-1:0]         q,
    input  logic                      save_data,
    input  logic                      data_clk,
    output logic                      data_out,
    output logic [NUM_CH*CNT_W-1:0]   err_cnt,
    output logic                      sat,
    output logic [1:0]                run_state
);
    localparam int SW = NUM_CH * CNT_W;
    typedef enum logic [1:0] {IDLE = 2'b00, FILL = 2'b01, RUN = 2'b10} state_t;
    state_t            state_q;
    logic [1:0]        mode_q;
    logic [3:0]        fill_q;
    logic              alt_q;
    logic [6:0]        lfsr_q;
    logic [LAT-1:0]    exp_q;
    logic [2:0]        save_q, dclk_q;
    logic [SW-1:0]     cnt_q, cnt_d, snap_q, snap_ld;
    logic [NUM_CH-1:0] err, full;
    logic              restart, save_edge, dclk_edge;

    // Leaving IDLE or a live mode change reseeds the generator and restarts the fill window
    assign restart   = en && (state_q == IDLE || mode != mode_q);
    assign save_edge = save_q[1] && !save_q[2];
    assign dclk_edge = dclk_q[1] && !dclk_q[2];
    assign dut_data  = state_q == IDLE ? 1'b0 : mode_q == 2'b01 ? alt_q : mode_q == 2'b11 ? lfsr_q[6] : mode_q[1];
    assign data_out  = snap_q[SW-1];
    assign err_cnt   = cnt_q;
    assign sat       = |full;
    assign run_state = state_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            mode_q  <= 2'b00;
            fill_q  <= '0;
            alt_q   <= 1'b0;
            lfsr_q  <= 7'h7F;
        end else begin
            mode_q <= mode;
            if (!en) begin
                state_q <= IDLE;
            end else if (restart) begin
                state_q <= FILL;
                fill_q  <= '0;
                alt_q   <= 1'b0;
                lfsr_q  <= 7'h7F;
            end else begin
                alt_q  <= ~alt_q;
                lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
                if (state_q == FILL) begin
                    fill_q <= fill_q + 4'd1;
                    if (fill_q == 4'(LAT)) state_q <= RUN;
                end
            end
        end
    end

    // Channel 0 occupies the top of the snapshot so it leaves first, MSB first
    always_comb begin
        cnt_d   = cnt_q;
        err     = '0;
        full    = '0;
        snap_ld = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            err[i]  = state_q == RUN && q[i] != exp_q[LAT-1];
            full[i] = &cnt_q[i*CNT_W +: CNT_W];
            snap_ld[(NUM_CH-1-i)*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W];
            if (save_edge && CLR_ON_SAVE)
                cnt_d[i*CNT_W +: CNT_W] = CNT_W'(err[i]);
            else if (err[i] && !full[i])
                cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exp_q  <= '0;
            save_q <= '0;
            dclk_q <= '0;
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            exp_q  <= (exp_q << 1) | LAT'(dut_data);
            save_q <= {save_q[1:0], save_data};
            dclk_q <= {dclk_q[1:0], data_clk};
            cnt_q  <= cnt_d;
            snap_q <= save_edge ? snap_ld : dclk_edge ? snap_q << 1 : snap_q;
        end
    end
endmodule
